// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} shift_op_t;

  // Widest operand the bit-reverse helper can handle.
  localparam int unsigned MAX_W = 256;

  function automatic int unsigned shamt_width(input int unsigned w);
    return $clog2(w);
  endfunction

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[i] = x[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One right-shift mux level: shift by DIST when en, fill from the fill bit or wrap around.
module shift_level #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             fill,
  input  logic             rotate,
  output logic [WIDTH-1:0] q
);
  logic [DIST-1:0] top_bits;

  assign top_bits = rotate ? d[DIST-1:0] : {DIST{fill}};
  assign q        = en ? {top_bits, d[WIDTH-1:DIST]} : d;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with a global-stall valid/ready pipeline.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = shamt_width(WIDTH),
  parameter int unsigned PIPE    = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);
  localparam int unsigned L = (SHAMT_W + PIPE - 1) / PIPE;

  logic                         adv;
  logic [PIPE-1:0]              vld_pipe_q;
  logic [PIPE-1:0][WIDTH-1:0]   data_q;
  logic [PIPE-1:0][SHAMT_W-1:0] shamt_q;
  logic [PIPE-1:0][1:0]         op_q;
  logic [PIPE-1:0]              fill_q;
  logic [PIPE-1:0][TAG_W-1:0]   tag_q;
  logic                         zero_q;

  logic [WIDTH-1:0]   src_data  [PIPE];
  logic [SHAMT_W-1:0] src_shamt [PIPE];
  logic [1:0]         src_op    [PIPE];
  logic               src_fill  [PIPE];
  logic [TAG_W-1:0]   src_tag   [PIPE];
  logic               src_vld   [PIPE];
  logic [WIDTH-1:0]   data_d    [PIPE];

  function automatic logic [WIDTH-1:0] rev_w(input logic [WIDTH-1:0] x);
    logic [MAX_W-1:0] t;
    t = bitrev(MAX_W'(x), WIDTH);
    return t[WIDTH-1:0];
  endfunction

  assign out_valid = vld_pipe_q[PIPE-1];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_data  = data_q[PIPE-1];
  assign out_tag   = tag_q[PIPE-1];
  assign out_zero  = zero_q;

  for (genvar j = 0; j < PIPE; j++) begin : g_src
    if (j == 0) begin : g_in
      // Left shifts run through the right-shift core on the reversed operand.
      assign src_data[0]  = (in_op == OP_SLL) ? rev_w(in_data) : in_data;
      assign src_shamt[0] = in_shamt;
      assign src_op[0]    = in_op;
      assign src_fill[0]  = (in_op == OP_SRA) & in_data[WIDTH-1];
      assign src_tag[0]   = in_tag;
      assign src_vld[0]   = in_valid;
    end else begin : g_reg
      assign src_data[j]  = data_q[j-1];
      assign src_shamt[j] = shamt_q[j-1];
      assign src_op[j]    = op_q[j-1];
      assign src_fill[j]  = fill_q[j-1];
      assign src_tag[j]   = tag_q[j-1];
      assign src_vld[j]   = vld_pipe_q[j-1];
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    localparam int unsigned S = k / L;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;
    if (k % L == 0) begin : g_first
      assign d_in = src_data[S];
    end else begin : g_chain
      assign d_in = g_lvl[k-1].q;
    end
    shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .d      (d_in),
      .en     (src_shamt[S][k]),
      .fill   (src_fill[S]),
      .rotate (src_op[S] == OP_ROR),
      .q      (q)
    );
  end

  for (genvar j = 0; j < PIPE; j++) begin : g_stg
    localparam int unsigned LO = j * L;
    localparam int unsigned HI = ((j + 1) * L < SHAMT_W) ? (j + 1) * L : SHAMT_W;
    logic [WIDTH-1:0] res;
    if (HI > LO) begin : g_has
      assign res = g_lvl[HI-1].q;
    end else begin : g_pass
      assign res = src_data[j];
    end
    if (j == PIPE - 1) begin : g_last
      assign data_d[j] = (src_op[j] == OP_SLL) ? rev_w(res) : res;
    end else begin : g_mid
      assign data_d[j] = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
      shamt_q    <= '0;
      op_q       <= '0;
      fill_q     <= '0;
      tag_q      <= '0;
      zero_q     <= 1'b0;
    end else if (adv) begin
      for (int j = 0; j < PIPE; j++) begin
        vld_pipe_q[j] <= src_vld[j];
        data_q[j]     <= data_d[j];
        shamt_q[j]    <= src_shamt[j];
        op_q[j]       <= src_op[j];
        fill_q[j]     <= src_fill[j];
        tag_q[j]      <= src_tag[j];
      end
      zero_q <= (data_d[PIPE-1] == '0);
    end
  end

  // Every stage carries the full control word; bits no later stage consumes end here.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{shamt_q, op_q, fill_q};

endmodule
